// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcode/funct
// values, ula32 operation codes, datapath mux selects and the control word.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,
    S_FWAIT  = 5'd1,
    S_IRLD   = 5'd2,
    S_DECODE = 5'd3,
    S_RX     = 5'd4,
    S_RWB    = 5'd5,
    S_IX     = 5'd6,
    S_IWB    = 5'd7,
    S_MADDR  = 5'd8,
    S_MRD    = 5'd9,
    S_MWAIT  = 5'd10,
    S_MDRLD  = 5'd11,
    S_LWB    = 5'd12,
    S_MWR    = 5'd13,
    S_BRANCH = 5'd14,
    S_JUMP   = 5'd15,
    S_EXC    = 5'd16
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ULA_ADD = 3'd1;
  localparam logic [2:0] ULA_SUB = 3'd2;
  localparam logic [2:0] ULA_AND = 3'd3;

  localparam logic [1:0] PC_ULA   = 2'd0;
  localparam logic [1:0] PC_ALUO  = 2'd1;
  localparam logic [1:0] PC_JUMP  = 2'd2;
  localparam logic [1:0] PC_EXC   = 2'd3;

  localparam logic [1:0] ULAB_REG  = 2'd0;
  localparam logic [1:0] ULAB_4    = 2'd1;
  localparam logic [1:0] ULAB_SE   = 2'd2;
  localparam logic [1:0] ULAB_SE2  = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_write;
    logic       load_ir;
    logic       load_mdr;
    logic       ab_write;
    logic       aluout_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       sel_ula_A;
    logic [1:0] sel_ula_B;
    logic [2:0] ula_func;
  } ctrl_t;

  function automatic logic funct_legal(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
  endfunction

  function automatic logic [2:0] funct_to_ula(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ULA_SUB;
      FN_AND:  return ULA_AND;
      default: return ULA_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multicycle CPU control FSM with a memory-read wait counter.
// Define CTRL_EXC_EN to add the EXC state and the epc_write/exc_cause outputs.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       ula_zero,
  input  logic       ula_ovflw,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       iord,
  output logic       mem_write,
  output logic       load_ir,
  output logic       load_mdr,
  output logic       ab_write,
  output logic       aluout_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       sel_ula_A,
  output logic [1:0] sel_ula_B,
  output logic [2:0] ula_func,
  output logic [4:0] state_dbg
`ifdef CTRL_EXC_EN
  ,
  output logic       epc_write,
  output logic       exc_cause
`endif
);

  localparam logic [2:0] WAIT_LD = 3'(MEM_WAIT);

  state_t     r_state, w_next;
  logic [2:0] r_cnt, w_cnt_next;
  ctrl_t      w_ctrl, w_drv;
  state_t     w_illegal_next;

`ifdef CTRL_EXC_EN
  logic r_cause, w_cause_next;
  assign w_illegal_next = S_EXC;
`else
  logic w_unused_ovflw;
  assign w_unused_ovflw = ula_ovflw;
  assign w_illegal_next = S_FETCH;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
`ifdef CTRL_EXC_EN
      r_cause <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
`ifdef CTRL_EXC_EN
      r_cause <= w_cause_next;
`endif
    end
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
`ifdef CTRL_EXC_EN
    w_cause_next = r_cause;
`endif
    case (r_state)
      S_FETCH: begin
        w_cnt_next = WAIT_LD;
        w_next     = S_FWAIT;
      end
      S_FWAIT: begin
        w_cnt_next = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) w_next = S_IRLD;
      end
      S_IRLD:   w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next = funct_legal(funct) ? S_RX : w_illegal_next;
          OP_ADDI:      w_next = S_IX;
          OP_LW, OP_SW: w_next = S_MADDR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default:      w_next = w_illegal_next;
        endcase
`ifdef CTRL_EXC_EN
        w_cause_next = 1'b0;
`endif
      end
      S_RX: begin
        w_next = S_RWB;
`ifdef CTRL_EXC_EN
        if (ula_ovflw && (funct != FN_AND)) begin
          w_next       = S_EXC;
          w_cause_next = 1'b1;
        end
`endif
      end
      S_IX: begin
        w_next = S_IWB;
`ifdef CTRL_EXC_EN
        if (ula_ovflw) begin
          w_next       = S_EXC;
          w_cause_next = 1'b1;
        end
`endif
      end
      S_MADDR: w_next = (opcode == OP_SW) ? S_MWR : S_MRD;
      S_MRD: begin
        w_cnt_next = WAIT_LD;
        w_next     = S_MWAIT;
      end
      S_MWAIT: begin
        w_cnt_next = r_cnt - 3'd1;
        if (r_cnt <= 3'd1) w_next = S_MDRLD;
      end
      S_MDRLD: w_next = S_LWB;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_ctrl = '0;
    case (r_state)
      S_FETCH, S_FWAIT: w_ctrl.iord = 1'b0;
      S_IRLD: begin
        w_ctrl.load_ir   = 1'b1;
        w_ctrl.sel_ula_A = 1'b1;
        w_ctrl.sel_ula_B = ULAB_4;
        w_ctrl.ula_func  = ULA_ADD;
        w_ctrl.pc_src    = PC_ULA;
        w_ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        w_ctrl.ab_write     = 1'b1;
        w_ctrl.sel_ula_A    = 1'b1;
        w_ctrl.sel_ula_B    = ULAB_SE2;
        w_ctrl.ula_func     = ULA_ADD;
        w_ctrl.aluout_write = 1'b1;
      end
      S_RX: begin
        w_ctrl.ula_func     = funct_to_ula(funct);
        w_ctrl.aluout_write = 1'b1;
      end
      S_IX, S_MADDR: begin
        w_ctrl.sel_ula_B    = ULAB_SE;
        w_ctrl.ula_func     = ULA_ADD;
        w_ctrl.aluout_write = 1'b1;
      end
      S_RWB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.reg_dst   = 1'b1;
      end
      S_IWB: w_ctrl.reg_write = 1'b1;
      S_MRD, S_MWAIT: w_ctrl.iord = 1'b1;
      S_MDRLD: begin
        w_ctrl.iord     = 1'b1;
        w_ctrl.load_mdr = 1'b1;
      end
      S_LWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
      end
      S_MWR: begin
        w_ctrl.iord      = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      S_BRANCH: begin
        // Only Mealy output: the branch decision depends on this cycle's zero flag.
        w_ctrl.ula_func = ULA_SUB;
        w_ctrl.pc_src   = PC_ALUO;
        w_ctrl.pc_write = (opcode == OP_BNE) ? ~ula_zero : ula_zero;
      end
      S_JUMP: begin
        w_ctrl.pc_src   = PC_JUMP;
        w_ctrl.pc_write = 1'b1;
      end
      S_EXC: begin
        w_ctrl.sel_ula_A = 1'b1;
        w_ctrl.sel_ula_B = ULAB_4;
        w_ctrl.ula_func  = ULA_SUB;
        w_ctrl.pc_src    = PC_EXC;
        w_ctrl.pc_write  = 1'b1;
      end
      default: w_ctrl = '0;
    endcase
  end

  assign w_drv        = reset ? '0 : w_ctrl;
  assign pc_write     = w_drv.pc_write;
  assign pc_src       = w_drv.pc_src;
  assign iord         = w_drv.iord;
  assign mem_write    = w_drv.mem_write;
  assign load_ir      = w_drv.load_ir;
  assign load_mdr     = w_drv.load_mdr;
  assign ab_write     = w_drv.ab_write;
  assign aluout_write = w_drv.aluout_write;
  assign reg_write    = w_drv.reg_write;
  assign reg_dst      = w_drv.reg_dst;
  assign mem_to_reg   = w_drv.mem_to_reg;
  assign sel_ula_A    = w_drv.sel_ula_A;
  assign sel_ula_B    = w_drv.sel_ula_B;
  assign ula_func     = w_drv.ula_func;
  assign state_dbg    = r_state;

`ifdef CTRL_EXC_EN
  assign epc_write = ~reset && (r_state == S_EXC);
  assign exc_cause = ~reset && (r_state == S_EXC) && r_cause;
`endif

endmodule
